ro_freq_counter: RTL and testbench

- Downstream measurement stage for the ring-oscillator tile: counts rising edges of the (pre-divided) RO output over a programmable gate window of system-clock cycles.
- Latches the result and exposes it byte-wise for the tile's dedicated outputs.
- Converts the RO's free-running toggle into a readable frequency code, so RO characterisation can be done from chip pins.

---
 rtl/ro_freq_counter.sv | 153 +++++++++++++++
 tb/tb_ro_freq_counter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/ro_freq_counter.sv
// Ring-oscillator frequency counter: counts synchronized rising edges of ro_in over a
// programmable 2^(MIN_LOG2+win_sel) cycle gate window and exposes the latched result byte-wise.
module ro_freq_counter #(
  parameter  int unsigned CNT_W    = 16,
  parameter  int unsigned MIN_LOG2 = 10,
  parameter  int unsigned SEL_W    = 3,
  localparam int unsigned BSEL_W   = (CNT_W / 8 > 1) ? $clog2(CNT_W / 8) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              ro_in,
  input  logic              start,
  input  logic [SEL_W-1:0]  win_sel,
  input  logic [BSEL_W-1:0] byte_sel,
  output logic [7:0]        count_out,
  output logic              busy,
  output logic              done,
  output logic              overflow
);

  localparam int unsigned NUM_BYTES = CNT_W / 8;
  localparam int unsigned WIN_W     = MIN_LOG2 + (1 << SEL_W);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_MEASURE
  } state_t;

  state_t state_q, state_d;

  logic              sync1_q, ro_s_q, ro_s_d_q;
  logic              arm_cnt_q;
  logic [SEL_W-1:0]  win_sel_q;
  logic [WIN_W-1:0]  win_cnt_q;
  logic [CNT_W-1:0]  edge_cnt_q, result_q;
  logic              edge_ovf_q;
  logic              busy_q, done_q, ovf_q;

  logic              edge_c, sat_c, win_last_c;
  logic              accept_c, arm_end_c, meas_end_c;
  logic [WIN_W-1:0]  win_max_c;
  logic [CNT_W-1:0]  cnt_nxt_c;
  logic              ovf_nxt_c;

  // Edge pulse and saturating next-count, shared by counting and final latch
  always_comb begin
    edge_c     = ro_s_q & ~ro_s_d_q;
    sat_c      = &edge_cnt_q;
    cnt_nxt_c  = (edge_c && !sat_c) ? edge_cnt_q + CNT_W'(1) : edge_cnt_q;
    ovf_nxt_c  = edge_ovf_q | (edge_c & sat_c);
    win_max_c  = ((WIN_W'(1) << MIN_LOG2) << win_sel_q) - WIN_W'(1);
    win_last_c = (win_cnt_q == win_max_c);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state and per-cycle control strobes; ena low aborts from any state
  always_comb begin
    state_d    = state_q;
    accept_c   = 1'b0;
    arm_end_c  = 1'b0;
    meas_end_c = 1'b0;
    if (!ena) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            accept_c = 1'b1;
            state_d  = S_ARM;
          end
        end
        S_ARM: begin
          if (arm_cnt_q) begin
            arm_end_c = 1'b1;
            state_d   = S_MEASURE;
          end
        end
        S_MEASURE: begin
          if (win_last_c) begin
            meas_end_c = 1'b1;
            state_d    = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= 1'b0;
      ro_s_q     <= 1'b0;
      ro_s_d_q   <= 1'b0;
      arm_cnt_q  <= 1'b0;
      win_sel_q  <= '0;
      win_cnt_q  <= '0;
      edge_cnt_q <= '0;
      edge_ovf_q <= 1'b0;
      result_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      sync1_q   <= ro_in;
      ro_s_q    <= sync1_q;
      ro_s_d_q  <= ro_s_q;
      busy_q    <= (state_d != S_IDLE);
      // Second ARM cycle is flagged so ARM lasts exactly two cycles
      arm_cnt_q <= (state_q == S_ARM) && (state_d == S_ARM);

      if (accept_c) begin
        win_sel_q  <= win_sel;
        edge_cnt_q <= '0;
        edge_ovf_q <= 1'b0;
        done_q     <= 1'b0;
        ovf_q      <= 1'b0;
      end

      if (arm_end_c) begin
        win_cnt_q <= '0;
      end else if (ena && state_q == S_MEASURE) begin
        win_cnt_q  <= win_cnt_q + WIN_W'(1);
        edge_cnt_q <= cnt_nxt_c;
        edge_ovf_q <= ovf_nxt_c;
      end

      if (meas_end_c) begin
        result_q <= cnt_nxt_c;
        ovf_q    <= ovf_nxt_c;
        done_q   <= 1'b1;
      end
    end
  end

  // Byte mux of the latched result; unmapped selects read as zero
  always_comb begin
    count_out = 8'h00;
    for (int i = 0; i < int'(NUM_BYTES); i++) begin
      if (BSEL_W'(i) == byte_sel) count_out = result_q[i*8 +: 8];
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_ro_freq_counter.sv
// Self-checking bench for ro_freq_counter: a default-size instance plus a narrow 8-bit
// instance (for saturation within a short run), checked against an edge-trace model.
module tb_ro_freq_counter;

  localparam int HIST_N = 131072;

  logic       clk, rst_n, ena, ro_in;
  logic       start, s_start;
  logic [2:0] win_sel, s_win_sel;
  logic       byte_sel, s_byte_sel;
  logic [7:0] count_out, s_count_out;
  logic       busy, done, overflow;
  logic       s_busy, s_done, s_overflow;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int hi_len = 4, lo_len = 4, ro_run = 0;
  bit hist [0:HIST_N-1];
  int last_res = 0;

  ro_freq_counter dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ro_in(ro_in), .start(start),
    .win_sel(win_sel), .byte_sel(byte_sel), .count_out(count_out),
    .busy(busy), .done(done), .overflow(overflow)
  );

  ro_freq_counter #(.CNT_W(8), .MIN_LOG2(4), .SEL_W(3)) dut_s (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ro_in(ro_in), .start(s_start),
    .win_sel(s_win_sel), .byte_sel(s_byte_sel), .count_out(s_count_out),
    .busy(s_busy), .done(s_done), .overflow(s_overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // RO waveform: high for hi_len cycles, low for lo_len; the value held in each cycle is logged
  initial begin
    ro_in = 1'b0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      ro_run++;
      if (ro_in && ro_run >= hi_len) begin
        ro_in = 1'b0; ro_run = 0;
      end else if (!ro_in && ro_run >= lo_len) begin
        ro_in = 1'b1; ro_run = 0;
      end
      if (cyc < HIST_N) hist[cyc] = ro_in;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Rising edges of ro_in entering the window: cycles lo..hi of the logged trace
  function automatic int count_edges(input int lo, input int hi);
    int n = 0;
    for (int j = lo; j <= hi; j++) if (hist[j] && !hist[j-1]) n++;
    return n;
  endfunction

  task automatic start_run(input bit sm, input logic [2:0] ws, input string tag, output int a);
    @(posedge clk); #1;
    if (sm) begin s_win_sel = ws; s_start = 1'b1; end
    else    begin win_sel = ws;   start = 1'b1;   end
    a = cyc;
    @(posedge clk); #1;
    start = 1'b0; s_start = 1'b0;
    chk({tag, "_busy_rise"}, sm ? s_busy : busy, 1);
    chk({tag, "_done_clr"}, sm ? s_done : done, 0);
  endtask

  task automatic finish_run(input bit sm, input logic [2:0] ws, input int a, input string tag,
                            output int res);
    int w, lat, n, maxv, expr;
    w = 1 << ((sm ? 4 : 10) + int'(ws));
    maxv = sm ? 255 : 65535;
    lat = 0;
    while (!(sm ? s_done : done) && lat < w + 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, cyc - a, 3 + w);
    chk({tag, "_busy_fall"}, sm ? s_busy : busy, 0);
    n = count_edges(a + 1, a + w);
    expr = (n > maxv) ? maxv : n;
    if (sm) begin
      s_byte_sel = 1'b0; #1;
      res = int'(s_count_out);
      s_byte_sel = 1'b1; #1;
      chk({tag, "_byte_oob"}, s_count_out, 0);
      chk({tag, "_ovf"}, s_overflow, (n > maxv) ? 1 : 0);
    end else begin
      byte_sel = 1'b0; #1;
      res = int'(count_out);
      byte_sel = 1'b1; #1;
      res = res | (int'(count_out) << 8);
      chk({tag, "_ovf"}, overflow, (n > maxv) ? 1 : 0);
      last_res = expr;
    end
    chk({tag, "_result"}, res, expr);
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) begin @(posedge clk); #1; end
  endtask

  initial begin
    int a, res;
    rst_n = 1'b0; ena = 1'b1; start = 1'b0; s_start = 1'b0;
    win_sel = '0; s_win_sel = '0; byte_sel = 1'b0; s_byte_sel = 1'b0;
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_count", count_out, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) @(posedge clk);

    // Basic: period 8, shortest window
    hi_len = 4; lo_len = 4;
    start_run(0, 3'd0, "basic", a);
    finish_run(0, 3'd0, a, "basic", res);
    chk("basic_128", res, 128);

    // Longer window, period 6
    hi_len = 3; lo_len = 3;
    repeat (10) @(posedge clk);
    start_run(0, 3'd2, "long", a);
    finish_run(0, 3'd2, a, "long", res);
    chk("long_range", (res == 682 || res == 683) ? 1 : 0, 1);
    repeat (50) @(posedge clk);
    #1 chk("long_done_sticky", done, 1);

    // Randomized waveforms and windows
    for (int k = 0; k < 4; k++) begin
      hi_len = int'($urandom_range(1, 9));
      lo_len = int'($urandom_range(1, 9));
      repeat (int'($urandom_range(3, 30))) @(posedge clk);
      start_run(0, 3'($urandom_range(0, 2)), "rand", a);
      finish_run(0, win_sel, a, "rand", res);
    end

    // Start while busy is ignored
    hi_len = 4; lo_len = 4;
    repeat (10) @(posedge clk);
    start_run(0, 3'd0, "busy_start", a);
    wait_to(a + 100);
    win_sel = 3'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; win_sel = 3'd0;
    finish_run(0, 3'd0, a, "busy_start", res);
    chk("busy_start_128", res, 128);
    repeat (20) @(posedge clk);
    #1 chk("busy_start_no_rerun", busy, 0);

    // Abort via ena low in MEASURE
    start_run(0, 3'd0, "abort", a);
    wait_to(a + 503);
    ena = 1'b0;
    @(posedge clk); #1;
    ena = 1'b1;
    byte_sel = 1'b0; #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_result_keep", count_out, last_res & 8'hFF);
    repeat (1100) @(posedge clk);
    #1 chk("abort_stays_idle", busy, 0);
    start_run(0, 3'd1, "post_abort", a);
    finish_run(0, 3'd1, a, "post_abort", res);

    // Saturation on the narrow instance, then a clean run clears overflow
    hi_len = 1; lo_len = 1;
    repeat (10) @(posedge clk);
    start_run(1, 3'd5, "sat", a);
    finish_run(1, 3'd5, a, "sat", res);
    chk("sat_ff", res, 255);
    chk("sat_ovf_set", s_overflow, 1);
    hi_len = 4; lo_len = 4;
    repeat (10) @(posedge clk);
    start_run(1, 3'd2, "unsat", a);
    finish_run(1, 3'd2, a, "unsat", res);
    chk("unsat_ovf_clr", s_overflow, 0);

    // Asynchronous reset mid-measurement with ro_in toggling
    start_run(0, 3'd0, "rst_mid", a);
    wait_to(a + 200);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_done", done, 0);
    chk("rst_mid_ovf", overflow, 0);
    chk("rst_mid_count_b1", count_out, 0);
    chk("rst_mid_s_done", s_done, 0);
    @(negedge clk);
    byte_sel = 1'b0; s_byte_sel = 1'b0; #1;
    chk("rst_mid_count_b0", count_out, 0);
    chk("rst_mid_s_count", s_count_out, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    last_res = 0;
    start_run(0, 3'd0, "after_rst", a);
    finish_run(0, 3'd0, a, "after_rst", res);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
